pipe_mux_n: RTL and testbench

- Parametrised N-way, WIDTH-bit data selector with a 2-entry registered skid buffer on the output. This is the pipelined-datapath successor to the combinational 2:1 select.
- Sits between pipeline stages: operand/forwarding selection, and writeback source selection.
- Adds a valid/ready handshake, stall absorption, flush, and out-of-range select detection.

---
 rtl/pipe_mux_n_pkg.sv | 19 +
 rtl/mux_n_sel.sv | 33 +++
 rtl/pipe_mux_n.sv | 132 +++++++++++++
 tb/tb_pipe_mux_n.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/pipe_mux_n_pkg.sv
// Shared definitions for the pipelined N-way selector family.
//   - ST_EMPTY / ST_ONE / ST_FULL : occupancy encoding of the 2-entry skid buffer
//   - clog2_min1()               : select-width helper, never returns less than 1
package mux_pkg;

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    // A 1-input or 2-input selector still needs a 1-bit select port.
    function automatic int clog2_min1(input int n);
        if (n <= 32'sd2) begin
            return 32'sd1;
        end else begin
            return $clog2(n);
        end
    endfunction

endpackage

// File: rtl/mux_n_sel.sv
// Combinational N-way WIDTH-bit selector with out-of-range detection.
// Ports:
//   sel  [SEL_W-1:0]        : input index
//   din  [NUM_IN*WIDTH-1:0] : flattened inputs, input k at din[k*WIDTH +: WIDTH]
//   data [WIDTH-1:0]        : selected word, zero when sel is out of range
//   err                     : sel >= NUM_IN
module mux_n_sel
    import mux_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 4,
    localparam int SEL_W = clog2_min1(NUM_IN)
) (
    input  logic [SEL_W-1:0]        sel,
    input  logic [NUM_IN*WIDTH-1:0] din,
    output logic [WIDTH-1:0]        data,
    output logic                    err
);

    // One extra bit so NUM_IN == 2**SEL_W is representable.
    localparam logic [SEL_W:0] NUM_IN_L = (SEL_W + 1)'(NUM_IN);

    // AND-OR selection: an out-of-range index matches no slice, so data
    // falls out as zero without a separate clearing path.
    always_comb begin
        data = '0;
        err  = ({1'b0, sel} >= NUM_IN_L);
        for (int k = 0; k < NUM_IN; k++) begin
            data = data | (din[k*WIDTH +: WIDTH] & {WIDTH{sel == SEL_W'(k)}});
        end
    end

endmodule

// File: rtl/pipe_mux_n.sv
// N-way WIDTH-bit selector feeding a 2-entry registered skid buffer.
// Ports:
//   clk, reset       : rising-edge clock, synchronous active-high reset
//   sel, din         : select and flattened inputs, sampled on accept
//   in_valid/in_ready: upstream handshake (in_ready straight from a flop)
//   flush            : drop every buffered entry, beats a same-cycle accept
//   dout, out_err    : head entry data / out-of-range flag
//   out_valid/out_ready : downstream handshake
module pipe_mux_n
    import mux_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 4,
    localparam int SEL_W = clog2_min1(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [SEL_W-1:0]        sel,
    input  logic [NUM_IN*WIDTH-1:0] din,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    flush,
    output logic [WIDTH-1:0]        dout,
    output logic                    out_err,
    output logic                    out_valid,
    input  logic                    out_ready
);

    // Entry layout: {err, data}.
    logic [WIDTH-1:0] sel_data_s;
    logic             sel_err_s;
    logic [WIDTH:0]   entry_s;

    logic [1:0]       state_r;
    logic [1:0]       state_nxt_s;
    logic [WIDTH:0]   head_r;
    logic [WIDTH:0]   head_nxt_s;
    logic [WIDTH:0]   skid_r;
    logic [WIDTH:0]   skid_nxt_s;
    logic             in_ready_r;
    logic             out_valid_r;
    logic             accept_s;
    logic             pop_s;

    mux_n_sel #(
        .WIDTH  (WIDTH),
        .NUM_IN (NUM_IN)
    ) u_sel (
        .sel  (sel),
        .din  (din),
        .data (sel_data_s),
        .err  (sel_err_s)
    );

    assign entry_s  = {sel_err_s, sel_data_s};
    assign accept_s = in_valid & in_ready_r;
    assign pop_s    = out_valid_r & out_ready;

    // Next-state and next-entry logic of the skid buffer.
    always_comb begin
        state_nxt_s = state_r;
        head_nxt_s  = head_r;
        skid_nxt_s  = skid_r;
        case (state_r)
            ST_EMPTY: begin
                if (accept_s) begin
                    head_nxt_s  = entry_s;
                    state_nxt_s = ST_ONE;
                end else begin
                    state_nxt_s = ST_EMPTY;
                end
            end
            ST_ONE: begin
                if (accept_s && pop_s) begin
                    head_nxt_s  = entry_s;
                    state_nxt_s = ST_ONE;
                end else if (accept_s) begin
                    skid_nxt_s  = entry_s;
                    state_nxt_s = ST_FULL;
                end else if (pop_s) begin
                    state_nxt_s = ST_EMPTY;
                end else begin
                    state_nxt_s = ST_ONE;
                end
            end
            ST_FULL: begin
                // in_ready is low here, so only a pop can move the buffer.
                if (pop_s) begin
                    head_nxt_s  = skid_r;
                    state_nxt_s = ST_ONE;
                end else begin
                    state_nxt_s = ST_FULL;
                end
            end
            default: begin
                state_nxt_s = ST_EMPTY;
            end
        endcase
        // Flush empties the buffer; stored data is left as is since it is
        // only observable together with out_valid.
        if (flush) begin
            state_nxt_s = ST_EMPTY;
            head_nxt_s  = head_r;
            skid_nxt_s  = skid_r;
        end else begin
            state_nxt_s = state_nxt_s;
        end
    end

    // State, entry storage and registered handshake flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_EMPTY;
            head_r      <= '0;
            skid_r      <= '0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            head_r      <= head_nxt_s;
            skid_r      <= skid_nxt_s;
            in_ready_r  <= (state_nxt_s != ST_FULL);
            out_valid_r <= (state_nxt_s != ST_EMPTY);
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign dout      = head_r[WIDTH-1:0];
    assign out_err   = head_r[WIDTH];

endmodule

// File: tb/tb_pipe_mux_n.sv
// Directed bench for pipe_mux_n: a 4-input instance (u0) for streaming,
// backpressure, flush, mid-run reset and accept+pop, and a 3-input
// instance (u1) for out-of-range select handling.
module tb_pipe_mux_n;

    logic clk = 1'b0;
    logic reset;

    // u0: WIDTH=32, NUM_IN=4
    logic [1:0]   sel0;
    logic [127:0] din0;
    logic         in_valid0, in_ready0, flush0, out_err0, out_valid0, out_ready0;
    logic [31:0]  dout0;

    // u1: WIDTH=32, NUM_IN=3 (SEL_W=2)
    logic [1:0]   sel1;
    logic [95:0]  din1;
    logic         in_valid1, in_ready1, flush1, out_err1, out_valid1, out_ready1;
    logic [31:0]  dout1;

    logic [31:0] words [4];
    int total = 0;
    int bad   = 0;

    pipe_mux_n #(.WIDTH(32), .NUM_IN(4)) u0 (
        .clk(clk), .reset(reset), .sel(sel0), .din(din0),
        .in_valid(in_valid0), .in_ready(in_ready0), .flush(flush0),
        .dout(dout0), .out_err(out_err0), .out_valid(out_valid0),
        .out_ready(out_ready0)
    );

    pipe_mux_n #(.WIDTH(32), .NUM_IN(3)) u1 (
        .clk(clk), .reset(reset), .sel(sel1), .din(din1),
        .in_valid(in_valid1), .in_ready(in_ready1), .flush(flush1),
        .dout(dout1), .out_err(out_err1), .out_valid(out_valid1),
        .out_ready(out_ready1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are then sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        words[0] = 32'hA0A0_A0A0;
        words[1] = 32'hB1B1_B1B1;
        words[2] = 32'hC2C2_C2C2;
        words[3] = 32'hD3D3_D3D3;
        din0 = {words[3], words[2], words[1], words[0]};
        din1 = {words[2], words[1], words[0]};
        sel0 = 2'd0; sel1 = 2'd0;
        flush0 = 1'b0; flush1 = 1'b0;
        out_ready0 = 1'b1; out_ready1 = 1'b1;
        in_valid1 = 1'b0;

        // Reset held 2 cycles with a transfer offered
        reset = 1'b1; in_valid0 = 1'b1;
        step(); step();
        chk("rst_valid", 64'(out_valid0), 64'd0);
        chk("rst_dout",  64'(dout0),      64'd0);
        chk("rst_ready", 64'(in_ready0),  64'd1);
        chk("rst_err",   64'(out_err0),   64'd0);
        reset = 1'b0; in_valid0 = 1'b0;
        step();
        chk("rst_no_entry", 64'(out_valid0), 64'd0);

        // Streaming sel=0..3 with out_ready=1
        in_valid0 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sel0 = 2'(i);
            step();
            chk("stream_valid", 64'(out_valid0), 64'd1);
            chk("stream_dout",  64'(dout0),      64'(words[i]));
            chk("stream_ready", 64'(in_ready0),  64'd1);
        end
        in_valid0 = 1'b0;
        step();
        chk("stream_drain", 64'(out_valid0), 64'd0);

        // Backpressure: three offers, two taken
        out_ready0 = 1'b0; in_valid0 = 1'b1; sel0 = 2'd0;
        step();
        chk("bp_first_dout",  64'(dout0),     64'(words[0]));
        chk("bp_first_ready", 64'(in_ready0), 64'd1);
        sel0 = 2'd1;
        step();
        chk("bp_full_ready", 64'(in_ready0), 64'd0);
        chk("bp_full_dout",  64'(dout0),     64'(words[0]));
        sel0 = 2'd2;
        step();
        chk("bp_refused_ready", 64'(in_ready0),  64'd0);
        chk("bp_hold_dout",     64'(dout0),      64'(words[0]));
        chk("bp_hold_valid",    64'(out_valid0), 64'd1);
        in_valid0 = 1'b0; out_ready0 = 1'b1;
        step();
        chk("bp_pop1_dout",  64'(dout0),     64'(words[1]));
        chk("bp_pop1_ready", 64'(in_ready0), 64'd1);
        step();
        chk("bp_pop2_empty", 64'(out_valid0), 64'd0);

        // Flush in FULL with in_valid high
        out_ready0 = 1'b0; in_valid0 = 1'b1; sel0 = 2'd0;
        step();
        sel0 = 2'd1;
        step();
        chk("fl_full", 64'(in_ready0), 64'd0);
        sel0 = 2'd3; flush0 = 1'b1;
        step();
        chk("fl_valid", 64'(out_valid0), 64'd0);
        chk("fl_ready", 64'(in_ready0),  64'd1);
        flush0 = 1'b0; in_valid0 = 1'b0;
        step();
        chk("fl_stay_empty", 64'(out_valid0), 64'd0);

        // Flush beats a same-cycle accept in ONE
        in_valid0 = 1'b1; sel0 = 2'd2;
        step();
        chk("fl1_dout", 64'(dout0), 64'(words[2]));
        sel0 = 2'd3; flush0 = 1'b1;
        step();
        chk("fl1_valid", 64'(out_valid0), 64'd0);
        chk("fl1_ready", 64'(in_ready0),  64'd1);
        flush0 = 1'b0; in_valid0 = 1'b0;
        step();
        chk("fl1_dropped", 64'(out_valid0), 64'd0);

        // Reset mid-operation while FULL
        in_valid0 = 1'b1; sel0 = 2'd0;
        step();
        sel0 = 2'd1;
        step();
        in_valid0 = 1'b0; reset = 1'b1;
        step();
        chk("mrst_valid", 64'(out_valid0), 64'd0);
        chk("mrst_ready", 64'(in_ready0),  64'd1);
        chk("mrst_dout",  64'(dout0),      64'd0);
        reset = 1'b0;
        step();
        chk("mrst_empty", 64'(out_valid0), 64'd0);

        // Eight cycles of simultaneous accept and pop
        out_ready0 = 1'b1; in_valid0 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            sel0 = 2'((i * 3) % 4);
            step();
            chk("ap_valid", 64'(out_valid0), 64'd1);
            chk("ap_ready", 64'(in_ready0),  64'd1);
            chk("ap_dout",  64'(dout0),      64'(words[(i * 3) % 4]));
        end
        in_valid0 = 1'b0;
        step();
        chk("ap_drain", 64'(out_valid0), 64'd0);

        // Out-of-range select on the 3-input instance
        in_valid1 = 1'b1; sel1 = 2'd3;
        step();
        chk("oor_valid", 64'(out_valid1), 64'd1);
        chk("oor_dout",  64'(dout1),      64'd0);
        chk("oor_err",   64'(out_err1),   64'd1);
        sel1 = 2'd1;
        step();
        chk("inr1_dout", 64'(dout1),    64'(words[1]));
        chk("inr1_err",  64'(out_err1), 64'd0);
        sel1 = 2'd2;
        step();
        chk("inr2_dout", 64'(dout1),    64'(words[2]));
        chk("inr2_err",  64'(out_err1), 64'd0);
        in_valid1 = 1'b0;
        step();
        chk("oor_drain", 64'(out_valid1), 64'd0);

        // Stalled error entry stays stable
        out_ready1 = 1'b0; in_valid1 = 1'b1; sel1 = 2'd3;
        step();
        in_valid1 = 1'b0;
        step();
        chk("oor_hold_err",   64'(out_err1),   64'd1);
        chk("oor_hold_valid", 64'(out_valid1), 64'd1);
        chk("oor_hold_dout",  64'(dout1),      64'd0);
        out_ready1 = 1'b1;
        step();
        chk("oor_hold_drain", 64'(out_valid1), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
